// File: rtl/percept_host.sv
// Host-side initiator for the percept UART bus: sends an addr/op/data frame on tx
// and, for read opcodes, waits for a single reply byte on rx or times out.
module percept_host #(
    parameter int CLK_PER_BIT    = 868,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       tx,
    input  logic       rx
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [15:0]   TOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_WAIT = 2'd2} state_e;
    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_e;

    state_e        state_q;
    logic [28:0]   frame_q;
    logic [4:0]    tx_bit_q;
    logic [CW-1:0] tx_cnt_q;
    logic [15:0]   tout_q;
    logic          read_q;
    logic          tx_q;
    logic          ready_q;
    logic          rsp_valid_q;
    logic          rsp_timeout_q;
    logic [7:0]    rsp_data_q;

    rx_e           rx_st_q;
    logic          rx_meta_q;
    logic          rx_sync_q;
    logic          rx_prev_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_idx_q;
    logic [7:0]    rx_shift_q;

    logic [28:0]   frame_d;
    logic          rx_good_s;

    // The leading start bit is driven directly on accept, so only the remaining 29 bits are queued.
    assign frame_d   = {1'b1, cmd_data, 1'b0, 1'b1, cmd_op, 1'b0, 1'b1, cmd_addr};
    assign rx_good_s = (rx_st_q == RX_STOP) && (rx_cnt_q == BIT_LAST) && rx_sync_q;

    // Transaction FSM: accept, serialise three bytes, then await reply or timeout.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q       <= ST_IDLE;
            frame_q       <= '1;
            tx_bit_q      <= 5'd0;
            tx_cnt_q      <= '0;
            tout_q        <= 16'd0;
            read_q        <= 1'b0;
            tx_q          <= 1'b1;
            ready_q       <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= 8'd0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && ready_q) begin
                        frame_q  <= frame_d;
                        read_q   <= cmd_op[7];
                        tx_q     <= 1'b0;
                        tx_bit_q <= 5'd0;
                        tx_cnt_q <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= ST_SEND;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 5'd29) begin
                            tx_q   <= 1'b1;
                            tout_q <= 16'd0;
                            if (read_q) begin
                                state_q <= ST_WAIT;
                            end else begin
                                state_q <= ST_IDLE;
                                ready_q <= 1'b1;
                            end
                        end else begin
                            tx_bit_q <= tx_bit_q + 5'd1;
                            tx_q     <= frame_q[0];
                            frame_q  <= {1'b1, frame_q[28:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    // A completing good frame outranks a timeout expiring on the same cycle.
                    if (rx_good_s) begin
                        rsp_data_q  <= rx_shift_q;
                        rsp_valid_q <= 1'b1;
                        ready_q     <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (rx_st_q != RX_IDLE) begin
                        tout_q <= tout_q;
                    end else if (tout_q == TOUT_LAST) begin
                        rsp_timeout_q <= 1'b1;
                        ready_q       <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        tout_q <= tout_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // Free-running 8N1 receiver; it stays frame-aligned even when no reply is expected.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= 3'd0;
            rx_shift_q <= 8'd0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            case (rx_st_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_st_q  <= RX_START;
                        rx_cnt_q <= '0;
                    end else begin
                        rx_cnt_q <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        rx_idx_q <= 3'd0;
                        rx_st_q  <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_idx_q == 3'd7) begin
                            rx_st_q <= RX_STOP;
                        end else begin
                            rx_idx_q <= rx_idx_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        rx_st_q  <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    rx_st_q  <= RX_IDLE;
                    rx_cnt_q <= '0;
                end
            endcase
        end
    end

    assign cmd_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign tx          = tx_q;

endmodule

// File: tb/tb_percept_host.sv
// Randomised scoreboard bench for percept_host: a UART decoder checks tx bytes and a
// response monitor checks rsp pulses against expectations queued by the stimulus.
module tb_percept_host;

    localparam int CPB  = 4;
    localparam int TOUT = 200;
    localparam int SEND_CLKS = 30 * CPB;

    logic       clk = 1'b0;
    logic       nRst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_addr, cmd_op, cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       tx;
    logic       rx;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit         is_tout;
        logic [7:0] data;
        int         tmin;
        int         tmax;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tx_exp_q[$];
    bit         tx_mon_en = 1'b1;
    logic [7:0] last_rsp  = 8'h00;

    percept_host #(.CLK_PER_BIT(CPB), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .nRst(nRst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .tx(tx), .rx(rx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every rsp pulse must match the head of the scoreboard queue.
    exp_t mon_e;
    initial forever begin
        @(negedge clk);
        if (nRst === 1'b1 && (rsp_valid === 1'b1 || rsp_timeout === 1'b1)) begin
            check("rsp_exclusive", {31'd0, rsp_valid & rsp_timeout}, 32'd0);
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {30'd0, rsp_valid, rsp_timeout}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                if (rsp_valid === 1'b1) begin
                    check("rsp_kind", {31'd0, mon_e.is_tout}, 32'd0);
                    check("rsp_data", {24'd0, rsp_data}, {24'd0, mon_e.data});
                    check("rsp_ready", {31'd0, cmd_ready}, 32'd1);
                end else begin
                    check("tout_kind", {31'd0, mon_e.is_tout}, 32'd1);
                    check("tout_cycle", cyc, (cyc < mon_e.tmin) ? mon_e.tmin :
                                             (cyc > mon_e.tmax) ? mon_e.tmax : cyc);
                end
            end
        end
    end

    // TX decoder: samples each bit at its centre and compares against queued bytes.
    logic [7:0] txm_b, txm_e;
    logic       txm_start, txm_stop;
    initial forever begin
        @(negedge clk);
        if (nRst === 1'b1 && tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            txm_start = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                txm_b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            txm_stop = tx;
            if (tx_mon_en) begin
                if (tx_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected: got byte %0h expected none", txm_b);
                end else begin
                    txm_e = tx_exp_q.pop_front();
                    check("tx_start", {31'd0, txm_start}, 32'd0);
                    check("tx_byte", {24'd0, txm_b}, {24'd0, txm_e});
                    check("tx_stop", {31'd0, txm_stop}, 32'd1);
                end
            end
        end
    end

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_v;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    // mode: 0 write, 1 read+reply, 2 read timeout, 3 read bad-stop then good, 4 read glitch then timeout
    task automatic do_cmd(input logic [7:0] a, input logic [7:0] o, input logic [7:0] d,
                          input int mode, input logic [7:0] reply, input int dly, input bit garbage);
        bit ok;
        int acc;
        exp_t e;
        wait_ready(2000, ok);
        check("ready_before_cmd", {31'd0, ok}, 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_op    = o;
        cmd_data  = d;
        tx_exp_q.push_back(a);
        tx_exp_q.push_back(o);
        tx_exp_q.push_back(d);
        @(negedge clk);
        acc       = cyc;
        cmd_valid = 1'b0;
        cmd_addr  = 8'($urandom);
        cmd_op    = 8'($urandom);
        cmd_data  = 8'($urandom);
        check("ready_drop", {31'd0, cmd_ready}, 32'd0);
        case (mode)
            0: begin
                if (garbage) begin
                    repeat (10) @(negedge clk);
                    uart_send(8'($urandom), 1'b1);
                end
                wait_ready(400, ok);
                check("write_busy_clks", cyc - acc, SEND_CLKS);
            end
            1: begin
                while (cyc < acc + SEND_CLKS + dly) @(negedge clk);
                e = '{is_tout: 1'b0, data: reply, tmin: 0, tmax: 0};
                exp_q.push_back(e);
                last_rsp = reply;
                uart_send(reply, 1'b1);
                wait_ready(400, ok);
            end
            2: begin
                e = '{is_tout: 1'b1, data: 8'h00, tmin: acc + SEND_CLKS + TOUT, tmax: acc + SEND_CLKS + TOUT};
                exp_q.push_back(e);
                wait_ready(800, ok);
            end
            3: begin
                while (cyc < acc + SEND_CLKS + 20) @(negedge clk);
                e = '{is_tout: 1'b0, data: reply, tmin: 0, tmax: 0};
                exp_q.push_back(e);
                last_rsp = reply;
                uart_send(8'h11, 1'b0);
                repeat (8) @(negedge clk);
                uart_send(reply, 1'b1);
                wait_ready(400, ok);
            end
            default: begin
                while (cyc < acc + SEND_CLKS + dly) @(negedge clk);
                e = '{is_tout: 1'b1, data: 8'h00, tmin: acc + SEND_CLKS + TOUT, tmax: acc + SEND_CLKS + TOUT + 6};
                exp_q.push_back(e);
                rx = 1'b0;
                @(negedge clk);
                rx = 1'b1;
                wait_ready(800, ok);
            end
        endcase
        check("txn_complete", {31'd0, ok}, 32'd1);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit idle_bad;
        int acc, mode;
        logic [7:0] op;
        nRst      = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = 8'h00;
        cmd_op    = 8'h00;
        cmd_data  = 8'h00;
        rx        = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        nRst = 1'b1;

        idle_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0)
                idle_bad = 1'b1;
        end
        check("idle_100_clks", {31'd0, idle_bad}, 32'd0);

        do_cmd(8'h05, 8'h01, 8'hA5, 0, 8'h00, 0, 1'b0);
        do_cmd(8'hFF, 8'h80, 8'h00, 1, 8'h3C, 20, 1'b0);
        do_cmd(8'h12, 8'h81, 8'h34, 2, 8'h00, 0, 1'b0);
        do_cmd(8'h40, 8'h82, 8'h99, 3, 8'h22, 0, 1'b0);
        do_cmd(8'h41, 8'hC0, 8'h00, 4, 8'h00, 30, 1'b0);

        for (int n = 0; n < 24; n++) begin
            mode = $urandom_range(0, 4);
            op   = 8'($urandom);
            op[7] = (mode != 0);
            do_cmd(8'($urandom), op, 8'($urandom), mode, 8'($urandom),
                   (mode == 4) ? $urandom_range(5, 100) : $urandom_range(0, 150), 1'($urandom));
        end

        // Reset in the middle of the second byte must release tx at once.
        check("rsp_data_hold", {24'd0, rsp_data}, {24'd0, last_rsp});
        tx_mon_en = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = 8'h5A;
        cmd_op    = 8'h00;
        cmd_data  = 8'hC3;
        @(negedge clk);
        acc       = cyc;
        cmd_valid = 1'b0;
        while (cyc < acc + 58) @(negedge clk);
        check("pre_reset_tx", {31'd0, tx}, 32'd0);
        #1;
        nRst = 1'b0;
        #1;
        check("mid_reset_tx", {31'd0, tx}, 32'd1);
        check("mid_reset_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_reset_rsp_data", {24'd0, rsp_data}, 32'd0);
        repeat (3) @(negedge clk);
        nRst     = 1'b1;
        last_rsp = 8'h00;
        repeat (60) @(negedge clk);
        tx_mon_en = 1'b1;
        do_cmd(8'hA7, 8'h3E, 8'h81, 0, 8'h00, 0, 1'b0);

        repeat (50) @(negedge clk);
        check("tx_queue_drained", tx_exp_q.size(), 32'd0);
        check("rsp_queue_drained", exp_q.size(), 32'd0);
        check("final_rsp_data", {24'd0, rsp_data}, {24'd0, last_rsp});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
